// File: rtl/mod_timebase_counter.sv
// rtl/mod_timebase_counter.sv - modulo-N up/down digit counter with prescaler, button adjust and load
// Carry/borrow pulse only on auto-advance wraps so that setting a field never ripples upward.
module mod_timebase_counter #(
    parameter int WIDTH       = 3,
    parameter int MODULUS     = 6,
    parameter int DIV         = 50000000,
    parameter int EXT_TICK    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic             i_tick_in,
    input  logic             i_count_up,
    input  logic             i_count_down,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_count,
    output logic             o_carry,
    output logic             o_borrow,
    output logic             o_tick_out
);
    localparam logic [WIDTH-1:0] CNT_MAX    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   LOAD_LIMIT = (WIDTH + 1)'(MODULUS);

    logic                   w_adv;
    logic [SYNC_STAGES-1:0] r_up_sync;
    logic [SYNC_STAGES-1:0] r_dn_sync;
    logic [SYNC_STAGES-1:0] r_vld;
    logic                   r_up_prev;
    logic                   r_dn_prev;
    logic                   r_up_armed;
    logic                   r_dn_armed;
    logic                   w_up_last;
    logic                   w_dn_last;
    logic                   w_up_edge;
    logic                   w_dn_edge;
    logic [WIDTH-1:0]       r_count;
    logic                   r_carry;
    logic                   r_borrow;
    logic [WIDTH-1:0]       w_count_nxt;
    logic                   w_carry_nxt;
    logic                   w_borrow_nxt;
    logic [WIDTH-1:0]       w_inc;
    logic [WIDTH-1:0]       w_dec;

    generate
        if (EXT_TICK == 0) begin : g_int_tick
            localparam int              PW        = (DIV > 1) ? $clog2(DIV) : 1;
            localparam logic [PW-1:0]   PRESC_MAX = PW'(DIV - 1);

            logic [PW-1:0] r_presc;
            logic          r_tick;
            logic          w_wrap;
            logic          w_unused;

            assign w_wrap   = i_en && (r_presc == PRESC_MAX);
            assign w_unused = i_tick_in;

            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    r_presc <= '0;
                    r_tick  <= 1'b0;
                end else begin
                    r_tick <= w_wrap;
                    if (i_load || w_wrap) begin
                        r_presc <= '0;
                    end else if (i_en) begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
            end

            assign w_adv      = r_tick;
            assign o_tick_out = r_tick;
        end else begin : g_ext_tick
            assign w_adv      = i_tick_in & i_en;
            assign o_tick_out = 1'b0;
        end
    endgenerate

    // r_vld marks when the synchroniser holds genuine samples; a button must be
    // seen released after reset before its edges are honoured.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_up_sync  <= '0;
            r_dn_sync  <= '0;
            r_vld      <= '0;
            r_up_prev  <= 1'b0;
            r_dn_prev  <= 1'b0;
            r_up_armed <= 1'b0;
            r_dn_armed <= 1'b0;
        end else begin
            r_up_sync  <= {r_up_sync[SYNC_STAGES-2:0], i_count_up};
            r_dn_sync  <= {r_dn_sync[SYNC_STAGES-2:0], i_count_down};
            r_vld      <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            r_up_prev  <= w_up_last;
            r_dn_prev  <= w_dn_last;
            r_up_armed <= r_up_armed | (r_vld[SYNC_STAGES-1] & ~w_up_last);
            r_dn_armed <= r_dn_armed | (r_vld[SYNC_STAGES-1] & ~w_dn_last);
        end
    end

    assign w_up_last = r_up_sync[SYNC_STAGES-1];
    assign w_dn_last = r_dn_sync[SYNC_STAGES-1];
    assign w_up_edge = w_up_last & ~r_up_prev & r_up_armed;
    assign w_dn_edge = w_dn_last & ~r_dn_prev & r_dn_armed;

    assign w_inc = (r_count == CNT_MAX) ? '0 : r_count + 1'b1;
    assign w_dec = (r_count == '0) ? CNT_MAX : r_count - 1'b1;

    always_comb begin
        w_count_nxt  = r_count;
        w_carry_nxt  = 1'b0;
        w_borrow_nxt = 1'b0;
        if (i_load) begin
            w_count_nxt = ({1'b0, i_load_value} >= LOAD_LIMIT) ? CNT_MAX : i_load_value;
        end else if (w_up_edge && w_dn_edge) begin
            w_count_nxt = r_count;
        end else if (w_up_edge) begin
            w_count_nxt = w_inc;
        end else if (w_dn_edge) begin
            w_count_nxt = w_dec;
        end else if (w_adv && !i_dir) begin
            w_count_nxt = w_inc;
            w_carry_nxt = (r_count == CNT_MAX);
        end else if (w_adv && i_dir) begin
            w_count_nxt  = w_dec;
            w_borrow_nxt = (r_count == '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_count  <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_carry  <= w_carry_nxt;
            r_borrow <= w_borrow_nxt;
        end
    end

    assign o_count  = r_count;
    assign o_carry  = r_carry;
    assign o_borrow = r_borrow;

endmodule

// File: tb/tb_mod_timebase_counter.sv
// tb/tb_mod_timebase_counter.sv - self-checking bench for mod_timebase_counter
module tb_mod_timebase_counter;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         checks = 0;
    int         errors = 0;
    logic [4:0] sb_q[$];
    logic [4:0] sb_exp;

    always #5 clk = ~clk;

    // Instance A: MODULUS=6, DIV=4
    logic       a_en = 1'b0, a_dir = 1'b0, a_up = 1'b0, a_dn = 1'b0, a_load = 1'b0;
    logic [2:0] a_lv = 3'd0;
    logic [2:0] a_count;
    logic       a_carry, a_borrow, a_tick;

    // Instance B: MODULUS=3, DIV=3
    logic       b_en = 1'b0, b_dir = 1'b0;
    logic [1:0] b_count;
    logic       b_carry, b_borrow, b_tick;

    // Cascade: lower MODULUS=6 DIV=1, upper MODULUS=3 on external tick
    logic       c_en = 1'b0;
    logic [2:0] lo_count;
    logic       lo_carry, lo_borrow, lo_tick;
    logic [1:0] hi_count;
    logic       hi_carry, hi_borrow, hi_tick;

    mod_timebase_counter #(.WIDTH(3), .MODULUS(6), .DIV(4), .EXT_TICK(0), .SYNC_STAGES(2)) u_a (
        .i_clk(clk), .i_rst(rst_n), .i_en(a_en), .i_dir(a_dir), .i_tick_in(1'b0),
        .i_count_up(a_up), .i_count_down(a_dn), .i_load(a_load), .i_load_value(a_lv),
        .o_count(a_count), .o_carry(a_carry), .o_borrow(a_borrow), .o_tick_out(a_tick));

    mod_timebase_counter #(.WIDTH(2), .MODULUS(3), .DIV(3), .EXT_TICK(0), .SYNC_STAGES(2)) u_b (
        .i_clk(clk), .i_rst(rst_n), .i_en(b_en), .i_dir(b_dir), .i_tick_in(1'b0),
        .i_count_up(1'b0), .i_count_down(1'b0), .i_load(1'b0), .i_load_value(2'd0),
        .o_count(b_count), .o_carry(b_carry), .o_borrow(b_borrow), .o_tick_out(b_tick));

    mod_timebase_counter #(.WIDTH(3), .MODULUS(6), .DIV(1), .EXT_TICK(0), .SYNC_STAGES(2)) u_lo (
        .i_clk(clk), .i_rst(rst_n), .i_en(c_en), .i_dir(1'b0), .i_tick_in(1'b0),
        .i_count_up(1'b0), .i_count_down(1'b0), .i_load(1'b0), .i_load_value(3'd0),
        .o_count(lo_count), .o_carry(lo_carry), .o_borrow(lo_borrow), .o_tick_out(lo_tick));

    mod_timebase_counter #(.WIDTH(2), .MODULUS(3), .DIV(1), .EXT_TICK(1), .SYNC_STAGES(2)) u_hi (
        .i_clk(clk), .i_rst(rst_n), .i_en(c_en), .i_dir(1'b0), .i_tick_in(lo_carry),
        .i_count_up(1'b0), .i_count_down(1'b0), .i_load(1'b0), .i_load_value(2'd0),
        .o_count(hi_count), .o_carry(hi_carry), .o_borrow(hi_borrow), .o_tick_out(hi_tick));

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_count, a_carry, a_borrow, a_tick} !== 6'b0) begin
            errors++;
            $display("FAIL reset_a: count=%0d carry=%b borrow=%b tick=%b, expected all 0", a_count, a_carry, a_borrow, a_tick);
        end
        checks++;
        if ({b_count, b_carry, b_borrow, b_tick} !== 5'b0) begin
            errors++;
            $display("FAIL reset_b: count=%0d carry=%b borrow=%b tick=%b, expected all 0", b_count, b_carry, b_borrow, b_tick);
        end
        checks++;
        if ({lo_count, hi_count, lo_carry, hi_carry, lo_tick, hi_tick} !== 9'b0) begin
            errors++;
            $display("FAIL reset_cascade: lo=%0d hi=%0d, expected 0 0", lo_count, hi_count);
        end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_free_run_up();
        int   n;
        logic stray;
        sb_q = {};
        for (int i = 1; i <= 7; i++) sb_q.push_back({3'(i % 6), (i == 6), 1'b0});
        a_dir = 1'b0;
        a_en  = 1'b1;
        for (int s = 0; s < 7; s++) begin
            n = 0;
            stray = 1'b0;
            do begin
                @(posedge clk); #1;
                n++;
                stray = stray | a_carry | a_borrow;
            end while (!a_tick && n < 12);
            checks++;
            if (n !== ((s == 0) ? 4 : 3)) begin
                errors++;
                $display("FAIL up_tick_interval step %0d: %0d cycles, expected %0d", s, n, (s == 0) ? 4 : 3);
            end
            checks++;
            if (stray !== 1'b0) begin
                errors++;
                $display("FAIL up_stray_pulse step %0d: carry/borrow seen between ticks, expected none", s);
            end
            @(posedge clk); #1;
            sb_exp = sb_q.pop_front();
            checks++;
            if ({a_count, a_carry, a_borrow} !== sb_exp) begin
                errors++;
                $display("FAIL up_step %0d: count=%0d carry=%b borrow=%b, expected count=%0d carry=%b borrow=%b",
                         s, a_count, a_carry, a_borrow, sb_exp[4:2], sb_exp[1], sb_exp[0]);
            end
        end
        a_en = 1'b0;
    endtask

    task automatic test_button();
        a_load = 1'b1; a_lv = 3'd3;
        @(posedge clk); #1;
        a_load = 1'b0;
        a_up = 1'b1;
        sb_q.push_back({3'd4, 2'b00});
        for (int e = 1; e <= 2; e++) begin
            @(posedge clk); #1;
            checks++;
            if (a_count !== 3'd3) begin
                errors++;
                $display("FAIL btn_latency edge %0d: count=%0d, expected 3", e, a_count);
            end
        end
        @(posedge clk); #1;
        sb_exp = sb_q.pop_front();
        checks++;
        if ({a_count, a_carry, a_borrow} !== sb_exp) begin
            errors++;
            $display("FAIL btn_up_step: count=%0d carry=%b, expected count=%0d carry=0", a_count, a_carry, sb_exp[4:2]);
        end
        repeat (17) @(posedge clk);
        #1;
        checks++;
        if (a_count !== 3'd4) begin
            errors++;
            $display("FAIL btn_held_once: count=%0d, expected 4", a_count);
        end
        a_up = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        a_up = 1'b1;
        sb_q.push_back({3'd5, 2'b00});
        repeat (3) @(posedge clk);
        #1;
        sb_exp = sb_q.pop_front();
        checks++;
        if ({a_count, a_carry, a_borrow} !== sb_exp) begin
            errors++;
            $display("FAIL btn_repress: count=%0d, expected %0d", a_count, sb_exp[4:2]);
        end
        a_up = 1'b0;
        a_load = 1'b1; a_lv = 3'd0;
        repeat (4) @(posedge clk);
        #1;
        a_load = 1'b0;
        a_dn = 1'b1;
        sb_q.push_back({3'd5, 2'b00});
        @(posedge clk); #1;
        a_dn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb_exp = sb_q.pop_front();
        checks++;
        if ({a_count, a_carry, a_borrow} !== sb_exp) begin
            errors++;
            $display("FAIL btn_down_wrap: count=%0d borrow=%b, expected count=5 borrow=0", a_count, a_borrow);
        end
        repeat (4) @(posedge clk);
        #1;
        a_up = 1'b1; a_dn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (a_count !== 3'd5) begin
            errors++;
            $display("FAIL btn_both: count=%0d, expected 5", a_count);
        end
        a_up = 1'b0; a_dn = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_load_collision();
        int n;
        a_en = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!a_tick && n < 12);
        checks++;
        if (a_tick !== 1'b1) begin
            errors++;
            $display("FAIL load_tick_wait: tick=%b after %0d cycles, expected 1", a_tick, n);
        end
        a_load = 1'b1; a_lv = 3'd2;
        sb_q.push_back({3'd2, 2'b00});
        @(posedge clk); #1;
        a_load = 1'b0;
        sb_exp = sb_q.pop_front();
        checks++;
        if ({a_count, a_carry, a_borrow} !== sb_exp) begin
            errors++;
            $display("FAIL load_collision: count=%0d carry=%b, expected count=2 carry=0", a_count, a_carry);
        end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!a_tick && n < 12);
        checks++;
        if (n !== 4 || a_count !== 3'd2) begin
            errors++;
            $display("FAIL load_presc_restart: tick after %0d cycles count=%0d, expected 4 cycles count=2", n, a_count);
        end
        sb_q.push_back({3'd3, 2'b00});
        @(posedge clk); #1;
        a_en = 1'b0;
        sb_exp = sb_q.pop_front();
        checks++;
        if ({a_count, a_carry, a_borrow} !== sb_exp) begin
            errors++;
            $display("FAIL load_next_tick: count=%0d, expected 3", a_count);
        end
        for (int k = 0; k < 3; k++) begin
            a_load = 1'b1;
            a_lv   = (k == 0) ? 3'd7 : (k == 1) ? 3'd6 : 3'd4;
            sb_q.push_back({(k == 2) ? 3'd4 : 3'd5, 2'b00});
            @(posedge clk); #1;
            a_load = 1'b0;
            sb_exp = sb_q.pop_front();
            checks++;
            if ({a_count, a_carry, a_borrow} !== sb_exp) begin
                errors++;
                $display("FAIL load_clamp value=%0d: count=%0d, expected %0d", a_lv, a_count, sb_exp[4:2]);
            end
        end
    endtask

    task automatic test_down_count();
        int   n;
        int   v;
        logic stray;
        sb_q = {};
        for (int i = 1; i <= 7; i++) begin
            v = (3 - (i % 3)) % 3;
            sb_q.push_back({1'b0, 2'(v), 1'b0, (v == 2)});
        end
        b_dir = 1'b1;
        b_en  = 1'b1;
        for (int s = 0; s < 7; s++) begin
            if (s == 5) begin
                b_en = 1'b0;
                stray = 1'b0;
                repeat (10) begin
                    @(posedge clk); #1;
                    stray = stray | b_tick | (b_count !== 2'd1);
                end
                checks++;
                if (stray !== 1'b0) begin
                    errors++;
                    $display("FAIL down_freeze: count/tick moved with en=0, expected count=1 tick=0");
                end
                b_en = 1'b1;
            end
            n = 0;
            stray = 1'b0;
            do begin
                @(posedge clk); #1;
                n++;
                stray = stray | b_carry | b_borrow;
            end while (!b_tick && n < 12);
            checks++;
            if (n !== ((s == 0) ? 3 : 2) || stray !== 1'b0) begin
                errors++;
                $display("FAIL down_tick step %0d: %0d cycles stray=%b, expected %0d cycles stray=0", s, n, stray, (s == 0) ? 3 : 2);
            end
            @(posedge clk); #1;
            sb_exp = sb_q.pop_front();
            checks++;
            if ({1'b0, b_count, b_carry, b_borrow} !== sb_exp) begin
                errors++;
                $display("FAIL down_step %0d: count=%0d carry=%b borrow=%b, expected count=%0d carry=0 borrow=%b",
                         s, b_count, b_carry, b_borrow, sb_exp[3:2], sb_exp[0]);
            end
        end
        b_en = 1'b0;
    endtask

    task automatic test_cascade();
        int         wraps;
        int         last_wrap;
        logic [1:0] hi_exp;
        logic [1:0] nxt;
        wraps = 0;
        last_wrap = 0;
        hi_exp = 2'd0;
        sb_q = {};
        c_en = 1'b1;
        for (int cyc = 1; cyc <= 40 && !(wraps == 3 && sb_q.size() == 0); cyc++) begin
            @(posedge clk); #1;
            if (sb_q.size() > 0) begin
                sb_exp = sb_q.pop_front();
                hi_exp = sb_exp[1:0];
                checks++;
                if ({3'b000, hi_count} !== sb_exp) begin
                    errors++;
                    $display("FAIL cascade_step cyc %0d: hi=%0d, expected %0d", cyc, hi_count, sb_exp[1:0]);
                end
            end else begin
                checks++;
                if (hi_count !== hi_exp) begin
                    errors++;
                    $display("FAIL cascade_hold cyc %0d: hi=%0d, expected %0d", cyc, hi_count, hi_exp);
                end
            end
            if (lo_carry) begin
                checks++;
                if (lo_count !== 3'd0) begin
                    errors++;
                    $display("FAIL cascade_lo_wrap cyc %0d: lo=%0d, expected 0", cyc, lo_count);
                end
                if (wraps > 0) begin
                    checks++;
                    if (cyc - last_wrap !== 6) begin
                        errors++;
                        $display("FAIL cascade_period: %0d cycles between carries, expected 6", cyc - last_wrap);
                    end
                end
                wraps++;
                last_wrap = cyc;
                nxt = (hi_exp == 2'd2) ? 2'd0 : hi_exp + 2'd1;
                sb_q.push_back({3'b000, nxt});
            end
        end
        checks++;
        if (wraps !== 3 || sb_q.size() !== 0 || hi_tick !== 1'b0) begin
            errors++;
            $display("FAIL cascade_done: wraps=%0d pending=%0d hi_tick=%b, expected 3 0 0", wraps, sb_q.size(), hi_tick);
        end
        c_en = 1'b0;
    endtask

    task automatic test_reset_async();
        a_en = 1'b1;
        a_load = 1'b1; a_lv = 3'd4;
        @(posedge clk); #1;
        a_load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a_up = 1'b1;
        @(posedge clk); #3;
        checks++;
        if (a_count !== 3'd4 || a_tick !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: count=%0d tick=%b, expected count=4 tick=1", a_count, a_tick);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_count, a_carry, a_borrow, a_tick} !== 6'b0) begin
            errors++;
            $display("FAIL rst_async: count=%0d carry=%b borrow=%b tick=%b, expected all 0", a_count, a_carry, a_borrow, a_tick);
        end
        a_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (a_count !== 3'd0) begin
            errors++;
            $display("FAIL rst_held_button: count=%0d, expected 0", a_count);
        end
        a_up = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        a_up = 1'b1;
        sb_q.push_back({3'd1, 2'b00});
        repeat (3) @(posedge clk);
        #1;
        sb_exp = sb_q.pop_front();
        checks++;
        if ({a_count, a_carry, a_borrow} !== sb_exp) begin
            errors++;
            $display("FAIL rst_repress: count=%0d, expected 1", a_count);
        end
        a_up = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run_up();
        test_button();
        test_load_collision();
        test_down_count();
        test_cascade();
        test_reset_async();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
